// File: rtl/pc_fetch_pkg.sv
// Shared types and default parameters for the fetch controller.
// Branch mode encoding matches the decode unit's branch_mode field.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BR_LT  = 2'd0,
    BR_NE  = 2'd1,
    BR_AL  = 2'd2,
    BR_ABS = 2'd3
  } br_mode_t;

  localparam int PC_W_DEF      = 8;
  localparam int OFF_W_DEF     = 8;
  localparam int RAS_DEPTH_DEF = 4;
  localparam int RESET_PC_DEF  = 0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with a top pointer and entry count.
// A push when full wraps onto the oldest entry.
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     replace,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] top_q, top_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW-1:0] waddr;
  logic [W-1:0]  mem_q [DEPTH];

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem_q[top_q];

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    unique case (1'b1)
      push: begin
        top_d = top_q + AW'(1);
        if (!full) cnt_d = cnt_q + (AW+1)'(1);
      end
      pop: begin
        if (!empty) begin
          top_d = top_q - AW'(1);
          cnt_d = cnt_q - (AW+1)'(1);
        end
      end
      default: ;
    endcase
  end

  assign waddr = push ? top_d : top_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Contents are don't-care after reset, so storage has no reset.
  always_ff @(posedge clk) begin
    if (push || replace) mem_q[waddr] <= wdata;
  end

endmodule

// File: rtl/pc_fetch_ctl.sv
// Program counter / fetch controller with branch modes and call/return.
// Priority: reset > halt > stall > ret/call > branch > sequential.
module pc_fetch_ctl
  import pc_fetch_pkg::*;
#(
  parameter int              PC_W      = PC_W_DEF,
  parameter int              OFF_W     = OFF_W_DEF,
  parameter int              RAS_DEPTH = RAS_DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(RESET_PC_DEF)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         halt,
  input  logic                         stall,
  input  logic                         branch_en,
  input  br_mode_t                     branch_mode,
  input  logic                         cmp_lt,
  input  logic                         cmp_ne,
  input  logic [OFF_W-1:0]             branch_off,
  input  logic [PC_W-1:0]              jump_addr,
  input  logic                         call,
  input  logic                         ret,
  output logic [PC_W-1:0]              pc,
  output logic                         taken,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            push, pop, replace;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty;

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_tgt;
  logic            br_tk;

  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(branch_off));

  always_comb begin
    br_tk  = 1'b0;
    br_tgt = pc_q + off_ext;
    unique case (branch_mode)
      BR_LT:  br_tk = cmp_lt;
      BR_NE:  br_tk = cmp_ne;
      BR_AL:  br_tk = 1'b1;
      BR_ABS: begin
        br_tk  = 1'b1;
        br_tgt = jump_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_inc;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    if (halt || stall) begin
      pc_d = pc_q;
    end else if (call && ret) begin
      // Tail call: swap the return address in place when one exists.
      pc_d    = jump_addr;
      taken_d = 1'b1;
      if (ras_empty) push    = 1'b1;
      else           replace = 1'b1;
    end else if (call) begin
      pc_d    = jump_addr;
      taken_d = 1'b1;
      push    = 1'b1;
      if (ras_full) ovf_d = 1'b1;
    end else if (ret) begin
      if (ras_empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = ras_top;
        taken_d = 1'b1;
        pop     = 1'b1;
      end
    end else if (branch_en && br_tk) begin
      pc_d    = br_tgt;
      taken_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .replace (replace),
    .wdata   (pc_inc),
    .rdata   (ras_top),
    .count   (ras_count),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  assign pc            = pc_q;
  assign taken         = taken_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// Bench for pc_fetch_ctl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then random stimulus.
module tb_pc_fetch_ctl;
  import pc_fetch_pkg::*;

  localparam int PC_W  = 8;
  localparam int OFF_W = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, halt, stall, branch_en, cmp_lt, cmp_ne;
  br_mode_t         mode;
  logic [OFF_W-1:0] off;
  logic [PC_W-1:0]  jaddr;
  logic             call, ret;
  logic [PC_W-1:0]  pc;
  logic             taken;
  logic [CW-1:0]    ras_count;
  logic             ovf, unf;

  int nvec = 0;
  int nerr = 0;

  logic [PC_W-1:0] m_pc;
  logic            m_taken, m_ovf, m_unf;
  logic [PC_W-1:0] m_ras [$];

  pc_fetch_ctl #(
    .PC_W      (PC_W),
    .OFF_W     (OFF_W),
    .RAS_DEPTH (DEPTH),
    .RESET_PC  ('0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .halt          (halt),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_mode   (mode),
    .cmp_lt        (cmp_lt),
    .cmp_ne        (cmp_ne),
    .branch_off    (off),
    .jump_addr     (jaddr),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .taken         (taken),
    .ras_count     (ras_count),
    .ras_overflow  (ovf),
    .ras_underflow (unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model from the rules: the RAS is a plain queue, newest at back.
  task automatic model_step();
    int o;
    bit tk;
    if (reset) begin
      m_pc = '0; m_taken = 0; m_ovf = 0; m_unf = 0;
      m_ras.delete();
    end else if (halt || stall) begin
      m_taken = 0;
    end else if (call && ret) begin
      if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + PC_W'(1);
      else                  m_ras.push_back(m_pc + PC_W'(1));
      m_pc = jaddr; m_taken = 1;
    end else if (call) begin
      if (m_ras.size() == DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1;
      end
      m_ras.push_back(m_pc + PC_W'(1));
      m_pc = jaddr; m_taken = 1;
    end else if (ret) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_taken = 1;
      end else begin
        m_unf = 1; m_pc = m_pc + PC_W'(1); m_taken = 0;
      end
    end else begin
      o  = int'($signed(off));
      tk = 0;
      if (branch_en) begin
        case (mode)
          BR_LT:   tk = cmp_lt;
          BR_NE:   tk = cmp_ne;
          default: tk = 1;
        endcase
      end
      if (tk && mode == BR_ABS) m_pc = jaddr;
      else if (tk)              m_pc = PC_W'(int'(m_pc) + o);
      else                      m_pc = m_pc + PC_W'(1);
      m_taken = tk;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("pc",        int'(pc),        int'(m_pc));
    chk("taken",     int'(taken),     int'(m_taken));
    chk("ras_count", int'(ras_count), m_ras.size());
    chk("overflow",  int'(ovf),       int'(m_ovf));
    chk("underflow", int'(unf),       int'(m_unf));
  endtask

  task automatic idle();
    reset = 0; halt = 0; stall = 0; branch_en = 0; mode = BR_LT;
    cmp_lt = 0; cmp_ne = 0; off = '0; jaddr = '0; call = 0; ret = 0;
  endtask

  task automatic goto_pc(input logic [PC_W-1:0] a);
    idle(); branch_en = 1; mode = BR_ABS; jaddr = a;
    tick();
    idle();
  endtask

  task automatic do_call(input logic [PC_W-1:0] a);
    idle(); call = 1; jaddr = a; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; tick(); idle();
  endtask

  initial begin
    idle();
    reset = 1; tick();
    chk("rst_pc", int'(pc), 0);
    chk("rst_taken", int'(taken), 0);
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_pc", int'(pc), i);
    end
    halt = 1; tick(); tick();
    chk("halt_pc", int'(pc), 3);
    reset = 1; tick();
    chk("rst_in_halt", int'(pc), 0);
    idle();

    goto_pc(8'd10);
    branch_en = 1; mode = BR_LT; cmp_lt = 1; off = 8'hFC; tick();
    chk("blt_tk_pc", int'(pc), 6);
    chk("blt_tk", int'(taken), 1);
    goto_pc(8'd10);
    branch_en = 1; mode = BR_LT; cmp_lt = 0; off = 8'hFC; tick();
    chk("blt_nt_pc", int'(pc), 11);
    chk("blt_nt", int'(taken), 0);
    goto_pc(8'd250);
    branch_en = 1; mode = BR_AL; off = 8'd10; tick();
    chk("bal_wrap", int'(pc), 4);
    goto_pc(8'h40);
    chk("babs", int'(pc), 'h40);

    goto_pc(8'd5);
    do_call(8'h20); do_call(8'h30); do_call(8'h50);
    chk("call_cnt", int'(ras_count), 3);
    do_ret(); chk("ret1", int'(pc), 'h31);
    do_ret(); chk("ret2", int'(pc), 'h21);
    do_ret(); chk("ret3", int'(pc), 6);
    do_ret();
    chk("ret4_pc", int'(pc), 7);
    chk("ret4_unf", int'(unf), 1);

    reset = 1; tick(); idle();
    do_call(8'h10); do_call(8'h20); do_call(8'h30);
    do_call(8'h40); do_call(8'h50);
    chk("ovf_flag", int'(ovf), 1);
    chk("ovf_cnt", int'(ras_count), 4);
    do_ret(); chk("lifo1", int'(pc), 'h41);
    do_ret(); chk("lifo2", int'(pc), 'h31);
    do_ret(); chk("lifo3", int'(pc), 'h21);
    do_ret(); chk("lifo4", int'(pc), 'h11);

    reset = 1; tick(); idle();
    goto_pc(8'h07);
    do_call(8'h12);
    stall = 1; call = 1; jaddr = 8'h70; tick();
    chk("stall_pc", int'(pc), 'h12);
    chk("stall_cnt", int'(ras_count), 1);
    idle();
    call = 1; ret = 1; jaddr = 8'h60; tick();
    chk("cr_pc", int'(pc), 'h60);
    chk("cr_cnt", int'(ras_count), 1);
    idle();
    do_ret(); chk("cr_top", int'(pc), 'h13);

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      halt      = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 9) == 0);
      call      = ($urandom_range(0, 5) == 0);
      ret       = ($urandom_range(0, 4) == 0);
      branch_en = $urandom_range(0, 1) == 1;
      mode      = br_mode_t'($urandom_range(0, 3));
      cmp_lt    = $urandom_range(0, 1) == 1;
      cmp_ne    = $urandom_range(0, 1) == 1;
      off       = OFF_W'($urandom);
      jaddr     = PC_W'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
